// File: rtl/controle_clock_io.sv
// controle_clock_io: execution-enable sequencer for the single-cycle core.
// It turns the control unit's enable_clock/halt codes and a raw push-button
// into cpu_enable, which gates the PC update and all architectural writes.
// IN/OUT instructions stall until the operator presses and releases the button.
// After that, exactly one instruction commits. A halt freezes the core until reset.
//
// Build option: define CONTROLE_CLOCK_DEBOUNCE_EN to include the debounce counter.
// Without it, the synchronized button feeds the edge detector directly.
module controle_clock_io #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] enable_clock,
  input  logic       halt,
  input  logic       button,
  output logic       cpu_enable,
  output logic       waiting_in,
  output logic       waiting_out,
  output logic       halted
);

  localparam logic [2:0] S_RUN          = 3'd0;
  localparam logic [2:0] S_WAIT_PRESS   = 3'd1;
  localparam logic [2:0] S_WAIT_RELEASE = 3'd2;
  localparam logic [2:0] S_STEP         = 3'd3;
  localparam logic [2:0] S_HALTED       = 3'd4;

  localparam logic KIND_IN  = 1'b0;
  localparam logic KIND_OUT = 1'b1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   btn_sync;
  logic                   btn_db;
  logic                   btn_db_prev;
  logic                   press;
  logic                   release_evt;

  logic [2:0] state_q;
  logic [2:0] state_d;
  logic       kind_q;
  logic       kind_d;
  logic       enable_c;
  logic       stall_code;

  // Bring the asynchronous button into the clock domain
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], button};
    end
  end

  assign btn_sync = sync_q[SYNC_STAGES-1];

`ifdef CONTROLE_CLOCK_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CNT_W-1:0] db_cnt;
  logic             btn_db_q;

  // The debounced level flips only after the synchronized input has disagreed with it
  // for long enough. Any agreement restarts the count, so short glitches never propagate.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      db_cnt   <= '0;
      btn_db_q <= 1'b0;
    end else if (btn_sync == btn_db_q) begin
      db_cnt <= '0;
    end else if (db_cnt == CNT_W'(DEBOUNCE_CYCLES)) begin
      btn_db_q <= ~btn_db_q;
      db_cnt   <= '0;
    end else begin
      db_cnt <= db_cnt + CNT_W'(1);
    end
  end

  assign btn_db = btn_db_q;
`else
  assign btn_db = btn_sync;
`endif

  // Previous debounced level, used for press/release edge detection
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      btn_db_prev <= 1'b0;
    end else begin
      btn_db_prev <= btn_db;
    end
  end

  assign press       =  btn_db & ~btn_db_prev;
  assign release_evt = ~btn_db &  btn_db_prev;

  // Codes 0 (IN) and 2 (OUT) stall; 1 and 3 both run
  assign stall_code = (enable_clock == 2'd0) || (enable_clock == 2'd2);

  // Next-state and commit decode.
  // The RUN enable is combinational, so ordinary instructions commit without a bubble.
  always_comb begin
    state_d  = state_q;
    kind_d   = kind_q;
    enable_c = 1'b0;
    case (state_q)
      S_RUN: begin
        enable_c = ~halt & ~stall_code;
        if (halt) begin
          state_d = S_HALTED;
        end else if (stall_code) begin
          state_d = S_WAIT_PRESS;
          kind_d  = enable_clock[1] ? KIND_OUT : KIND_IN;
        end
      end
      S_WAIT_PRESS: begin
        // A button already held on entry has no rising edge, so it must be released first
        if (press) begin
          state_d = S_WAIT_RELEASE;
        end
      end
      S_WAIT_RELEASE: begin
        if (release_evt) begin
          state_d = S_STEP;
        end
      end
      S_STEP: begin
        // The stalled IN/OUT commits here; the PC moves on, so RUN sees a fresh opcode
        enable_c = 1'b1;
        state_d  = S_RUN;
      end
      S_HALTED: begin
        state_d = S_HALTED;
      end
      default: begin
        state_d = S_RUN;
      end
    endcase
  end

  // Reset forces the enable low even though the RUN decode is combinational
  assign cpu_enable = enable_c & ~reset;

  // State and stalled-instruction kind
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_RUN;
      kind_q  <= KIND_IN;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
    end
  end

  // Status flags are registered from the next state, so they line up with state_q.
  // They have no combinational path from the button.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      waiting_in  <= 1'b0;
      waiting_out <= 1'b0;
      halted      <= 1'b0;
    end else begin
      waiting_in  <= ((state_d == S_WAIT_PRESS) || (state_d == S_WAIT_RELEASE)) && (kind_d == KIND_IN);
      waiting_out <= ((state_d == S_WAIT_PRESS) || (state_d == S_WAIT_RELEASE)) && (kind_d == KIND_OUT);
      halted      <= (state_d == S_HALTED);
    end
  end

endmodule
